// File: rtl/circ_queue_ptr_ctrl.sv
// Head/tail pointer controller for a multi-ported circular queue.
// Optional synchronous clear enabled by defining CQ_FLUSH_EN.
module circ_queue_ptr_ctrl #(
  parameter int DEPTH = 16,
  parameter int W     = 2,
  localparam int IDX  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_aL,
`ifdef CQ_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [W-1:0]     enq_req,
  input  logic [W-1:0]     deq_req,
  output logic [W-1:0]     enq_grant,
  output logic [W-1:0]     deq_grant,
  output logic [W*IDX-1:0] wr_idx,
  output logic [W*IDX-1:0] rd_idx,
  output logic [IDX:0]     count,
  output logic             full,
  output logic             empty
);

  typedef logic [IDX:0]   ptr_t;
  typedef logic [IDX-1:0] idx_t;

  localparam ptr_t ONE = ptr_t'(1);
  localparam ptr_t CAP = ptr_t'(DEPTH);

  ptr_t head, tail;
  ptr_t enq_cnt, deq_cnt;
  ptr_t free_cnt;
  ptr_t n_enq, n_deq;
  logic [W-1:0] enq_san, deq_san;
  logic enq_run, deq_run;
  logic clr;

`ifdef CQ_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign count    = tail - head;
  assign full     = (count == CAP);
  assign empty    = (count == '0);
  assign free_cnt = CAP - count;

  // Requests only count up to the first clear bit.
  always_comb begin
    enq_cnt = '0;
    deq_cnt = '0;
    enq_san = '0;
    deq_san = '0;
    enq_run = 1'b1;
    deq_run = 1'b1;
    for (int i = 0; i < W; i++) begin
      enq_run = enq_run & enq_req[i];
      deq_run = deq_run & deq_req[i];
      if (enq_run) begin
        enq_cnt    = enq_cnt + ONE;
        enq_san[i] = 1'b1;
      end
      if (deq_run) begin
        deq_cnt    = deq_cnt + ONE;
        deq_san[i] = 1'b1;
      end
    end
  end

  always_comb begin
    n_enq = (enq_cnt < free_cnt) ? enq_cnt : free_cnt;
    n_deq = (deq_cnt < count) ? deq_cnt : count;
    if (!rst_aL || clr) begin
      n_enq = '0;
      n_deq = '0;
    end
  end

  always_comb begin
    enq_grant = '0;
    deq_grant = '0;
    wr_idx    = '0;
    rd_idx    = '0;
    for (int i = 0; i < W; i++) begin
      enq_grant[i] = (ptr_t'(i) < n_enq);
      deq_grant[i] = (ptr_t'(i) < n_deq);
      wr_idx[i*IDX +: IDX] = tail[IDX-1:0] + idx_t'(i);
      rd_idx[i*IDX +: IDX] = head[IDX-1:0] + idx_t'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + n_deq;
      tail <= tail + n_enq;
    end
  end

`ifndef SYNTHESIS
  a_enq_thermo: assert property (@(posedge clk) disable iff (!rst_aL)
    enq_san == enq_req)
    else $warning("enq_req is not thermometer coded: %b", enq_req);
  a_deq_thermo: assert property (@(posedge clk) disable iff (!rst_aL)
    deq_san == deq_req)
    else $warning("deq_req is not thermometer coded: %b", deq_req);
  a_count_max: assert property (@(posedge clk) disable iff (!rst_aL)
    count <= CAP)
    else $error("occupancy above DEPTH: %0d", count);
`endif

endmodule

// File: tb/tb_circ_queue_ptr_ctrl.sv
// Directed bench for circ_queue_ptr_ctrl at DEPTH=4, W=2.
// Flush steps run only when CQ_FLUSH_EN is defined.
module tb_circ_queue_ptr_ctrl;

  localparam int DEPTH = 4;
  localparam int W     = 2;
  localparam int IDX   = 2;

  logic             clk = 1'b0;
  logic             rst_aL;
  logic             flush;
  logic [W-1:0]     enq_req, deq_req;
  logic [W-1:0]     enq_grant, deq_grant;
  logic [W*IDX-1:0] wr_idx, rd_idx;
  logic [IDX:0]     count;
  logic             full, empty;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  circ_queue_ptr_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk),
    .rst_aL(rst_aL),
`ifdef CQ_FLUSH_EN
    .flush(flush),
`endif
    .enq_req(enq_req),
    .deq_req(deq_req),
    .enq_grant(enq_grant),
    .deq_grant(deq_grant),
    .wr_idx(wr_idx),
    .rd_idx(rd_idx),
    .count(count),
    .full(full),
    .empty(empty)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_aL  = 1'b0;
    flush   = 1'b0;
    enq_req = 2'b00;
    deq_req = 2'b00;
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_enq_grant", enq_grant, 0);
    chk("rst_deq_grant", deq_grant, 0);
    chk("rst_wr_idx", wr_idx, 4'b0100);
    chk("rst_rd_idx", rd_idx, 4'b0100);
    rst_aL = 1'b1;

    // fill: two double enqueues
    enq_req = 2'b11;
    #1;
    chk("fill1_grant", enq_grant, 2'b11);
    chk("fill1_wr_idx", wr_idx, 4'b0100);
    tick();
    chk("fill2_count", count, 2);
    chk("fill2_grant", enq_grant, 2'b11);
    chk("fill2_wr_idx", wr_idx, 4'b1110);
    tick();
    chk("fill3_count", count, 4);
    chk("fill3_full", full, 1);
    chk("fill3_empty", empty, 0);
    chk("fill3_grant", enq_grant, 2'b00);

    // full queue with both sides requesting
    deq_req = 2'b11;
    #1;
    chk("fullboth_deq", deq_grant, 2'b11);
    chk("fullboth_enq", enq_grant, 2'b00);
    chk("fullboth_rd_idx", rd_idx, 4'b0100);
    tick();
    chk("fullboth_count", count, 2);
    chk("fullboth_full", full, 0);
    chk("fullboth_rd_next", rd_idx, 4'b1110);

    // move head to 3, tail to 5 (idx 1), count 2
    enq_req = 2'b00;
    deq_req = 2'b01;
    #1;
    chk("deq1_grant", deq_grant, 2'b01);
    tick();
    chk("deq1_count", count, 1);
    enq_req = 2'b01;
    deq_req = 2'b00;
    #1;
    chk("enq1_grant", enq_grant, 2'b01);
    chk("enq1_wr_idx", wr_idx, 4'b0100);
    tick();
    chk("enq1_count", count, 2);

    // dequeue across the head wrap
    enq_req = 2'b00;
    deq_req = 2'b11;
    #1;
    chk("hwrap_rd_idx", rd_idx, 4'b0011);
    chk("hwrap_grant", deq_grant, 2'b11);
    tick();
    chk("hwrap_count", count, 0);
    chk("hwrap_empty", empty, 1);
    chk("hwrap_rd_next", rd_idx, 4'b1001);

    // empty queue with both sides requesting
    enq_req = 2'b11;
    deq_req = 2'b11;
    #1;
    chk("empboth_enq", enq_grant, 2'b11);
    chk("empboth_deq", deq_grant, 2'b00);
    tick();
    chk("empboth_empty", empty, 0);
    chk("empboth_count", count, 2);

    // reset in the middle of a cycle
    deq_req = 2'b00;
    #1;
    chk("pre_rst_grant", enq_grant, 2'b11);
    rst_aL = 1'b0;
    #1;
    chk("midrst_grant", enq_grant, 2'b00);
    chk("midrst_count", count, 0);
    chk("midrst_wr_idx", wr_idx, 4'b0100);
    tick();
    rst_aL = 1'b1;
    chk("midrst_hold", count, 0);

    // tail index 3 -> 0 with partial grant
    tick();
    chk("tw_count2", count, 2);
    enq_req = 2'b01;
    tick();
    chk("tw_count3", count, 3);
    enq_req = 2'b11;
    #1;
    chk("tw_grant", enq_grant, 2'b01);
    chk("tw_wr_idx", wr_idx, 4'b0011);
    tick();
    chk("tw_count4", count, 4);
    chk("tw_full", full, 1);
    chk("tw_wr_next", wr_idx, 4'b0100);

    // non-thermometer requests grant nothing
    enq_req = 2'b00;
    deq_req = 2'b11;
    tick();
    chk("nt_pre_count", count, 2);
    enq_req = 2'b10;
    deq_req = 2'b10;
    #1;
    chk("nt_enq_grant", enq_grant, 2'b00);
    chk("nt_deq_grant", deq_grant, 2'b00);
    tick();
    chk("nt_count", count, 2);

`ifdef CQ_FLUSH_EN
    enq_req = 2'b01;
    deq_req = 2'b00;
    tick();
    chk("fl_pre_count", count, 3);
    flush   = 1'b1;
    enq_req = 2'b11;
    deq_req = 2'b11;
    #1;
    chk("fl_enq_grant", enq_grant, 2'b00);
    chk("fl_deq_grant", deq_grant, 2'b00);
    tick();
    flush = 1'b0;
    enq_req = 2'b00;
    deq_req = 2'b00;
    #1;
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_wr_idx", wr_idx, 4'b0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
